// File: rtl/draw_sequencer.sv
// Per-frame arbiter for the shared VGA write port: grants sprite clients in index
// order, forwards the granted client's pixel stream, and flags overruns and hung clients.
module draw_sequencer #(
  parameter int N_CLIENTS      = 4,
  parameter int FRAME_CYCLES   = 833333,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_CLIENTS-1:0]    client_mask,
  input  logic [N_CLIENTS-1:0]    client_WriteEn,
  input  logic [15*N_CLIENTS-1:0] client_coords,
  input  logic [9*N_CLIENTS-1:0]  client_colour,
  input  logic [N_CLIENTS-1:0]    client_done,
  output logic [N_CLIENTS-1:0]    enable_draw,
  output logic                    vga_plot,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [8:0]              vga_colour,
  output logic                    frame_tick,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int IW = $clog2(N_CLIENTS + 1);
  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT, WAIT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   to_q, to_d;
  logic [FW-1:0]   cnt_q;
  logic            tick_q;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            tmo_q, tmo_d;
  logic            plot_q;
  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic [8:0]      col_q;

  // Packed views of the flat client buses, one element per client.
  logic [N_CLIENTS-1:0][14:0] coords_a;
  logic [N_CLIENTS-1:0][8:0]  colour_a;
  assign coords_a = client_coords;
  assign colour_a = client_colour;

  // Selected-client view; all zero once idx has run past the last client.
  logic                 sel_valid, sel_mask, sel_we, sel_done;
  logic [14:0]          sel_coords;
  logic [8:0]           sel_col;
  logic [N_CLIENTS-1:0] sel_onehot;
  logic                 in_range;

  always_comb begin
    sel_valid  = 1'b0;
    sel_mask   = 1'b0;
    sel_we     = 1'b0;
    sel_done   = 1'b0;
    sel_coords = '0;
    sel_col    = '0;
    sel_onehot = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_valid     = 1'b1;
        sel_mask      = client_mask[i];
        sel_we        = client_WriteEn[i];
        sel_done      = client_done[i];
        sel_coords    = coords_a[i];
        sel_col       = colour_a[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign in_range = (sel_coords[14:7] <= 8'd159) && (sel_coords[6:0] <= 7'd119);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == FW'(FRAME_CYCLES - 1));
      cnt_q  <= (cnt_q == FW'(FRAME_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    to_d        = to_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    tmo_d       = tmo_q;
    enable_draw = '0;
    // Ticks landing mid-frame collapse into a single deferred frame start.
    if (tick_q && state_q != IDLE) begin
      pending_d = 1'b1;
      overrun_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (tick_q || pending_q) begin
          pending_d = 1'b0;
          idx_d     = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IW'(N_CLIENTS))  state_d = IDLE;
        else if (!sel_mask)           idx_d   = idx_q + 1'b1;
        else                          state_d = GRANT;
      end
      GRANT: begin
        enable_draw = sel_onehot;
        to_d        = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (sel_done) begin
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      to_q      <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      to_q      <= to_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      tmo_q     <= tmo_d;
    end
  end

  // Pixel fields track the granted client even when the write is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      plot_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      col_q  <= '0;
    end else begin
      plot_q <= (state_q == WAIT) && sel_we && in_range;
      if (sel_valid) begin
        x_q   <= sel_coords[14:7];
        y_q   <= sel_coords[6:0];
        col_q <= sel_col;
      end
    end
  end

  assign vga_plot    = plot_q;
  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign vga_colour  = col_q;
  assign frame_tick  = tick_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboard bench for draw_sequencer: a short-timeout instance (a) and a
// long-timeout instance (b) share stimulus; b is used for the overrun scenario.
module tb_draw_sequencer;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] col;
  } vga_t;

  logic        clk;
  logic        resetn;
  logic [3:0]  client_mask, client_WriteEn, client_done;
  logic [59:0] client_coords;
  logic [35:0] client_colour;

  logic [3:0] en_a, en_b;
  logic       plot_a, plot_b, tick_a, tick_b, busy_a, busy_b;
  logic       ovr_a, ovr_b, tmo_a, tmo_b;
  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [8:0] col_a, col_b;

  int n_checks = 0;
  int n_fail   = 0;
  int   exp_grant[$];
  vga_t exp_vga[$];

  draw_sequencer #(.N_CLIENTS(4), .FRAME_CYCLES(100), .TIMEOUT_CYCLES(20)) dut_a (
    .clk(clk), .resetn(resetn), .client_mask(client_mask), .client_WriteEn(client_WriteEn),
    .client_coords(client_coords), .client_colour(client_colour), .client_done(client_done),
    .enable_draw(en_a), .vga_plot(plot_a), .vga_x(x_a), .vga_y(y_a), .vga_colour(col_a),
    .frame_tick(tick_a), .busy(busy_a), .overrun(ovr_a), .timeout_err(tmo_a));

  draw_sequencer #(.N_CLIENTS(4), .FRAME_CYCLES(100), .TIMEOUT_CYCLES(200)) dut_b (
    .clk(clk), .resetn(resetn), .client_mask(client_mask), .client_WriteEn(client_WriteEn),
    .client_coords(client_coords), .client_colour(client_colour), .client_done(client_done),
    .enable_draw(en_b), .vga_plot(plot_b), .vga_x(x_b), .vga_y(y_b), .vga_colour(col_b),
    .frame_tick(tick_b), .busy(busy_b), .overrun(ovr_b), .timeout_err(tmo_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic set_client(input int i, input logic [7:0] x, input logic [6:0] y, input logic [8:0] c);
    client_coords[15*i +: 15] = {x, y};
    client_colour[9*i +: 9]   = c;
  endtask

  // Bounded wait for any enable_draw bit; returns the observed vector.
  task automatic wait_grant(input bit use_b, input int budget, output bit ok, output logic [3:0] got);
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      got = use_b ? en_b : en_a;
      if (got != 4'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    client_mask = 4'hF; client_WriteEn = 4'hF; client_done = 4'h0;
    client_coords = {4{15'h1234}}; client_colour = {4{9'h1FF}};
    resetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({en_a, en_b, plot_a, plot_b, tick_a, busy_a, ovr_a, tmo_a} !== 14'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl cyc%0d: en_a=%b en_b=%b plot=%b tick=%b busy=%b ovr=%b tmo=%b, want all 0",
                 c, en_a, en_b, plot_a, tick_a, busy_a, ovr_a, tmo_a);
      end
    end
    n_checks++;
    if ({x_a, y_a, col_a} !== 24'b0) begin
      n_fail++;
      $display("FAIL reset_vga: x=%0d y=%0d col=%h, want 0", x_a, y_a, col_a);
    end
  endtask

  task automatic test_order;
    bit ok; logic [3:0] got; int e;
    client_mask = 4'b1011; client_WriteEn = 4'h0; client_done = 4'h0;
    do_reset;
    exp_grant = '{0, 1, 3};
    for (int k = 0; k < 3; k++) begin
      wait_grant(1'b0, 300, ok, got);
      e = (exp_grant.size() != 0) ? exp_grant.pop_front() : 9;
      n_checks++;
      if (!ok || got !== (4'b0001 << e)) begin
        n_fail++;
        $display("FAIL order_grant%0d: got %b (seen=%0d), want %b", k, got, ok, 4'b0001 << e);
      end
      @(negedge clk);
      n_checks++;
      if (en_a !== 4'b0) begin
        n_fail++;
        $display("FAIL order_pulse_width%0d: en=%b, want 0000", k, en_a);
      end
      repeat (9) @(posedge clk);
      #1 client_done = 4'b0001 << e;
      @(posedge clk);
      #1 client_done = 4'h0;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || tmo_a !== 1'b0) begin
      n_fail++;
      $display("FAIL order_end: busy=%b tmo=%b, want 0 0", busy_a, tmo_a);
    end
  endtask

  task automatic test_forwarding;
    bit ok; logic [3:0] got; vga_t ev;
    logic [3:0] we_tab [4] = '{4'b0011, 4'b0011, 4'b0001, 4'b0010};
    logic       pl_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    client_mask = 4'b0010; client_WriteEn = 4'h0; client_done = 4'h0;
    do_reset;
    exp_grant.push_back(1);
    wait_grant(1'b0, 300, ok, got);
    n_checks++;
    if (!ok || got !== (4'b0001 << exp_grant.pop_front())) begin
      n_fail++;
      $display("FAIL fwd_grant: got %b, want 0010", got);
    end
    set_client(1, 8'd42, 7'd17, 9'h1C0);
    set_client(0, 8'd7, 7'd3, 9'h03F);
    for (int k = 0; k < 4; k++) begin
      client_WriteEn = we_tab[k];
      exp_vga.push_back('{plot: pl_tab[k], x: 8'd42, y: 7'd17, col: 9'h1C0});
      @(negedge clk);
      ev = exp_vga.pop_front();
      n_checks++;
      if ({plot_a, x_a, y_a, col_a} !== ev) begin
        n_fail++;
        $display("FAIL fwd_vga%0d: plot=%b x=%0d y=%0d col=%h, want plot=%b x=%0d y=%0d col=%h",
                 k, plot_a, x_a, y_a, col_a, ev.plot, ev.x, ev.y, ev.col);
      end
    end
    // Reset in the middle of a grant with a live write pending.
    client_WriteEn = 4'b0010;
    resetn = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy_a, plot_a, en_a, x_a, y_a, col_a} !== 30'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: busy=%b plot=%b en=%b x=%0d, want all 0", busy_a, plot_a, en_a, x_a);
    end
    resetn = 1'b1;
  endtask

  task automatic test_range;
    bit ok; logic [3:0] got; vga_t ev; logic [8:0] c;
    logic [7:0] xt [4] = '{8'd160, 8'd159, 8'd0,   8'd0};
    logic [6:0] yt [4] = '{7'd5,   7'd119, 7'd120, 7'd0};
    logic       pt [4] = '{1'b0,   1'b1,   1'b0,   1'b1};
    client_mask = 4'b0001; client_WriteEn = 4'h0; client_done = 4'h0;
    do_reset;
    exp_grant.push_back(0);
    wait_grant(1'b0, 300, ok, got);
    n_checks++;
    if (!ok || got !== (4'b0001 << exp_grant.pop_front())) begin
      n_fail++;
      $display("FAIL range_grant: got %b, want 0001", got);
    end
    @(negedge clk);
    client_WriteEn = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      c = 9'($urandom);
      set_client(0, xt[k], yt[k], c);
      exp_vga.push_back('{plot: pt[k], x: xt[k], y: yt[k], col: c});
      @(negedge clk);
      ev = exp_vga.pop_front();
      n_checks++;
      if ({plot_a, x_a, y_a, col_a} !== ev) begin
        n_fail++;
        $display("FAIL range%0d: plot=%b x=%0d y=%0d col=%h, want plot=%b x=%0d y=%0d col=%h",
                 k, plot_a, x_a, y_a, col_a, ev.plot, ev.x, ev.y, ev.col);
      end
    end
    client_WriteEn = 4'h0;
    client_done = 4'b0001;
    @(negedge clk);
    client_done = 4'h0;
  endtask

  task automatic test_timeout;
    bit ok; logic [3:0] got;
    client_mask = 4'b0011; client_WriteEn = 4'h0; client_done = 4'h0;
    do_reset;
    exp_grant = '{0, 1};
    wait_grant(1'b0, 300, ok, got);
    n_checks++;
    if (!ok || got !== (4'b0001 << exp_grant.pop_front()) || tmo_a !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_grant0: got %b tmo=%b, want 0001 0", got, tmo_a);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (tmo_a !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_early: tmo=%b after 19 WAIT cycles, want 0", tmo_a);
    end
    @(negedge clk);
    n_checks++;
    if (tmo_a !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_set: tmo=%b after 20 WAIT cycles, want 1", tmo_a);
    end
    @(negedge clk);
    n_checks++;
    if (en_a !== (4'b0001 << exp_grant.pop_front())) begin
      n_fail++;
      $display("FAIL tmo_next_grant: en=%b, want 0010", en_a);
    end
    client_mask = 4'h0;
  endtask

  task automatic test_overrun;
    bit ok; logic [3:0] got;
    client_mask = 4'b0001; client_WriteEn = 4'h0; client_done = 4'h0;
    do_reset;
    exp_grant = '{0, 0};
    wait_grant(1'b1, 300, ok, got);
    n_checks++;
    if (!ok || got !== (4'b0001 << exp_grant.pop_front()) || ovr_b !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_grant0: got %b ovr=%b, want 0001 0", got, ovr_b);
    end
    repeat (150) @(posedge clk);
    #1 client_done = 4'b0001;
    @(posedge clk);
    #1 client_done = 4'h0;
    n_checks++;
    if (ovr_b !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: overrun=%b, want 1", ovr_b);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_idle: busy=%b at frame end, want 0", busy_b);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (en_b !== (4'b0001 << exp_grant.pop_front())) begin
      n_fail++;
      $display("FAIL ovr_pending_frame: en=%b, want 0001", en_b);
    end
    client_mask = 4'h0;
  endtask

  task automatic test_stale_done;
    bit ok; logic [3:0] got;
    client_mask = 4'b0011; client_WriteEn = 4'h0; client_done = 4'b0001;
    do_reset;
    exp_grant = '{0, 1};
    wait_grant(1'b0, 300, ok, got);
    n_checks++;
    if (!ok || got !== (4'b0001 << exp_grant.pop_front())) begin
      n_fail++;
      $display("FAIL stale_grant0: got %b, want 0001", got);
    end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1 || en_a !== 4'b0) begin
      n_fail++;
      $display("FAIL stale_wait: busy=%b en=%b, want 1 0000", busy_a, en_a);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (en_a !== (4'b0001 << exp_grant.pop_front())) begin
      n_fail++;
      $display("FAIL stale_grant1: en=%b, want 0010", en_a);
    end
    client_done = 4'b0010;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || tmo_a !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_end: busy=%b tmo=%b, want 0 0", busy_a, tmo_a);
    end
    client_done = 4'h0;
  endtask

  initial begin
    resetn = 1'b0;
    client_mask = 4'h0; client_WriteEn = 4'h0; client_done = 4'h0;
    client_coords = '0; client_colour = '0;
    test_reset;
    test_order;
    test_forwarding;
    test_range;
    test_timeout;
    test_overrun;
    test_stale_done;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
